// File: rtl/afe_ro_pkg.sv
// Shared types and width helpers for the multi-channel AFE readout to uDMA bridge.
package afe_ro_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } afe_ro_state_e;

  // Channel tag needs at least one bit even when there is a single channel.
  function automatic int ch_width(input int nb_ch);
    return (nb_ch > 1) ? $clog2(nb_ch) : 1;
  endfunction

  function automatic int txn_width(input int nb_ch, input int data_w, input int addr_w);
    return ch_width(nb_ch) + 2 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/afe_ro_sync_fifo.sv
// Synchronous-reset FIFO with full/empty flags and occupancy count.
module afe_ro_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   usage
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign usage   = cnt;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/afe_ro_udma_mux_if.sv
// Round-robin merge of NB_CH AFE readout channels into one tagged uDMA RX stream,
// with a shutdown sequence that stops accepting, drains the buffer and reports done.
module afe_ro_udma_mux_if
  import afe_ro_pkg::*;
#(
  parameter int NB_CH          = 4,
  parameter int L2_DATA_WIDTH  = 32,
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              test_mode_i,
  input  logic [NB_CH-1:0]                  afero_valid_i,
  output logic [NB_CH-1:0]                  afero_ready_o,
  output logic [NB_CH-1:0]                  afero_buff_ce_o,
  input  logic [NB_CH*L2_DATA_WIDTH-1:0]    afero_wdata_i,
  input  logic [NB_CH*L2_AWIDTH_NOAL-1:0]   afero_addr_i,
  input  logic [NB_CH*2-1:0]                afero_size_i,
  input  logic                              udma_shtdwn_i,
  output logic                              shtdwn_done_o,
  input  logic                              udma_ready_i,
  output logic                              udma_valid_o,
  output logic [L2_DATA_WIDTH-1:0]          udma_data_o,
  output logic [L2_AWIDTH_NOAL-1:0]         udma_addr_o,
  output logic [1:0]                        udma_size_o,
  output logic [ch_width(NB_CH)-1:0]        udma_ch_o
);

  localparam int CH_W  = ch_width(NB_CH);
  localparam int TXN_W = txn_width(NB_CH, L2_DATA_WIDTH, L2_AWIDTH_NOAL);

  typedef struct packed {
    logic [CH_W-1:0]           ch;
    logic [1:0]                size;
    logic [L2_AWIDTH_NOAL-1:0] addr;
    logic [L2_DATA_WIDTH-1:0]  data;
  } afe_ro_txn_t;

  afe_ro_state_e                state_q, state_d;
  logic                         done_q;
  logic [CH_W-1:0]              rr_ptr_q;
  logic [CH_W-1:0]              gnt_idx;
  logic                         gnt_found;
  logic [NB_CH-1:0]             grant;
  logic                         accept_en;
  logic                         push, pop;
  logic                         fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]  usage;
  logic [TXN_W-1:0]             head_raw;
  afe_ro_txn_t                  push_txn, head_txn;
  logic                         unused_bits;

  assign unused_bits = ^{test_mode_i, usage};

  // Arbiter: first requesting channel at or after the round-robin pointer.
  always_comb begin
    int idx;
    grant     = '0;
    gnt_idx   = '0;
    gnt_found = 1'b0;
    idx       = 0;
    for (int k = 0; k < NB_CH; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NB_CH) idx = idx - NB_CH;
      if (!gnt_found && afero_valid_i[idx]) begin
        gnt_found  = 1'b1;
        gnt_idx    = CH_W'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

  // Gate on full rather than on udma_ready_i so a push never relies on a same-cycle pop.
  assign accept_en       = ~fifo_full & (state_q == ST_RUN) & ~udma_shtdwn_i;
  assign afero_ready_o   = grant & {NB_CH{accept_en}};
  assign afero_buff_ce_o = afero_valid_i & afero_ready_o;
  assign push            = |afero_buff_ce_o;
  assign pop             = ~fifo_empty & udma_ready_i;

  always_comb begin
    push_txn    = '0;
    push_txn.ch = gnt_idx;
    for (int i = 0; i < NB_CH; i++) begin
      if (grant[i]) begin
        push_txn.size = afero_size_i[i*2 +: 2];
        push_txn.addr = afero_addr_i[i*L2_AWIDTH_NOAL +: L2_AWIDTH_NOAL];
        push_txn.data = afero_wdata_i[i*L2_DATA_WIDTH +: L2_DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
    end else if (push) begin
      rr_ptr_q <= (gnt_idx == CH_W'(NB_CH-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  afe_ro_sync_fifo #(
    .WIDTH (TXN_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .push  (push),
    .wdata (push_txn),
    .pop   (pop),
    .rdata (head_raw),
    .full  (fifo_full),
    .empty (fifo_empty),
    .usage (usage)
  );

  // Stale storage never reaches the outputs once the buffer is empty.
  assign head_txn     = fifo_empty ? '0 : afe_ro_txn_t'(head_raw);
  assign udma_valid_o = ~fifo_empty;
  assign udma_data_o  = head_txn.data;
  assign udma_addr_o  = head_txn.addr;
  assign udma_size_o  = head_txn.size;
  assign udma_ch_o    = head_txn.ch;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:   if (udma_shtdwn_i) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!udma_shtdwn_i)  state_d = ST_RUN;
        else if (fifo_empty) state_d = ST_HALT;
      end
      ST_HALT:  if (!udma_shtdwn_i) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_RUN;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == ST_HALT);
    end
  end

  assign shtdwn_done_o = done_q;

endmodule

// File: tb/tb_afe_ro_udma_mux_if.sv
// Scoreboard bench: directed stimulus queues expected transactions, monitors check pops.
module tb_afe_ro_udma_mux_if;
  localparam int DW = 32;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic rst_n;
  logic tmode = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]      valid0, ready0, ce0;
  logic [4*DW-1:0] wdata0;
  logic [4*AW-1:0] addr0;
  logic [7:0]      size0;
  logic            shtdwn0, done0, uready0, uvalid0;
  logic [DW-1:0]   udata0;
  logic [AW-1:0]   uaddr0;
  logic [1:0]      usize0, uch0;

  logic            valid1, ready1, ce1;
  logic [DW-1:0]   wdata1;
  logic [AW-1:0]   addr1;
  logic [1:0]      size1;
  logic            shtdwn1, done1, uready1, uvalid1;
  logic [DW-1:0]   udata1;
  logic [AW-1:0]   uaddr1;
  logic [1:0]      usize1;
  logic [0:0]      uch1;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  logic [63:0] q0[$];
  logic [63:0] q1[$];

  afe_ro_udma_mux_if #(.NB_CH(4), .L2_DATA_WIDTH(DW), .L2_AWIDTH_NOAL(AW), .FIFO_DEPTH(4)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .test_mode_i(tmode),
    .afero_valid_i(valid0), .afero_ready_o(ready0), .afero_buff_ce_o(ce0),
    .afero_wdata_i(wdata0), .afero_addr_i(addr0), .afero_size_i(size0),
    .udma_shtdwn_i(shtdwn0), .shtdwn_done_o(done0), .udma_ready_i(uready0),
    .udma_valid_o(uvalid0), .udma_data_o(udata0), .udma_addr_o(uaddr0),
    .udma_size_o(usize0), .udma_ch_o(uch0)
  );

  afe_ro_udma_mux_if #(.NB_CH(1), .L2_DATA_WIDTH(DW), .L2_AWIDTH_NOAL(AW), .FIFO_DEPTH(2)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .test_mode_i(tmode),
    .afero_valid_i(valid1), .afero_ready_o(ready1), .afero_buff_ce_o(ce1),
    .afero_wdata_i(wdata1), .afero_addr_i(addr1), .afero_size_i(size1),
    .udma_shtdwn_i(shtdwn1), .shtdwn_done_o(done1), .udma_ready_i(uready1),
    .udma_valid_o(uvalid1), .udma_data_o(udata1), .udma_addr_o(uaddr1),
    .udma_size_o(usize1), .udma_ch_o(uch1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every field of every channel changes each cycle, so a wrong mux or stale entry shows up.
  task automatic update_inputs();
    for (int i = 0; i < 4; i++) begin
      wdata0[i*DW +: DW] = {8'(8'hD0 + i), 8'h00, 16'(cyc)};
      addr0[i*AW +: AW]  = {4'(i), 8'(cyc)};
      size0[i*2 +: 2]    = 2'(i) ^ 2'(cyc);
    end
    wdata1 = {8'hE1, 8'h00, 16'(cyc)};
    addr1  = {4'hF, 8'(cyc * 3)};
    size1  = 2'(cyc + 1);
  endtask

  task automatic tick(input logic [3:0] e_ce0, input logic e_done, input logic e_ce1);
    @(negedge clk);
    chk("ready0", ready0, e_ce0);
    chk("buff_ce0", ce0, e_ce0);
    chk("shtdwn_done", done0, e_done);
    chk("ready1", ready1, e_ce1);
    chk("buff_ce1", ce1, e_ce1);
    for (int i = 0; i < 4; i++)
      if (e_ce0[i]) q0.push_back({16'h0, 2'(i), size0[i*2 +: 2], addr0[i*AW +: AW], wdata0[i*DW +: DW]});
    if (e_ce1) q1.push_back({17'h0, 1'b0, size1, addr1, wdata1});
    @(posedge clk);
    #1;
    cyc++;
    update_inputs();
  endtask

  task automatic reset_checks();
    chk("rst_udma_valid0", uvalid0, 0);
    chk("rst_udma_data0", udata0, 0);
    chk("rst_udma_addr0", uaddr0, 0);
    chk("rst_udma_ch0", uch0, 0);
    chk("rst_done0", done0, 0);
    chk("rst_udma_valid1", uvalid1, 0);
  endtask

  always @(negedge clk) begin
    if (uvalid0 && uready0) begin
      if (q0.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL d0_pop: got %0h, required no transaction", {uch0, usize0, uaddr0, udata0});
      end else chk("d0_pop", {16'h0, uch0, usize0, uaddr0, udata0}, q0.pop_front());
    end
  end

  always @(negedge clk) begin
    if (uvalid1 && uready1) begin
      if (q1.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL d1_pop: got %0h, required no transaction", {uch1, usize1, uaddr1, udata1});
      end else chk("d1_pop", {17'h0, uch1, usize1, uaddr1, udata1}, q1.pop_front());
    end
  end

  initial begin
    rst_n = 1'b0;
    valid0 = '0; shtdwn0 = 1'b0; uready0 = 1'b0;
    valid1 = 1'b0; shtdwn1 = 1'b0; uready1 = 1'b0;
    update_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    reset_checks();

    // Round robin over four requesters, drained immediately.
    uready0 = 1'b1; valid0 = 4'hF;
    tick(4'h1, 0, 0); tick(4'h2, 0, 0); tick(4'h4, 0, 0); tick(4'h8, 0, 0); tick(4'h1, 0, 0);
    valid0 = 4'h0;
    repeat (3) tick(4'h0, 0, 0);

    // Fill to depth with ch1, blocked on full, then pop and push in one cycle.
    uready0 = 1'b0; valid0 = 4'h2;
    repeat (4) tick(4'h2, 0, 0);
    tick(4'h0, 0, 0);
    uready0 = 1'b1;
    tick(4'h0, 0, 0);
    tick(4'h2, 0, 0);
    valid0 = 4'h0;
    repeat (5) tick(4'h0, 0, 0);

    // Shutdown with three buffered: no accepts, drain, done, then resume.
    uready0 = 1'b0; valid0 = 4'h4;
    repeat (3) tick(4'h4, 0, 0);
    shtdwn0 = 1'b1; uready0 = 1'b1;
    repeat (4) tick(4'h0, 0, 0);
    tick(4'h0, 1, 0); tick(4'h0, 1, 0);
    shtdwn0 = 1'b0;
    tick(4'h0, 1, 0);
    tick(4'h4, 0, 0);
    valid0 = 4'h0;
    repeat (2) tick(4'h0, 0, 0);

    // Reset with two buffered; pointer must restart at channel 0.
    uready0 = 1'b0; valid0 = 4'h2;
    tick(4'h2, 0, 0); tick(4'h2, 0, 0);
    valid0 = 4'h0; rst_n = 1'b0;
    q0.delete();
    tick(4'h0, 0, 0);
    rst_n = 1'b1;
    reset_checks();
    valid0 = 4'hA;
    tick(4'h2, 0, 0);
    valid0 = 4'h0; uready0 = 1'b1;
    repeat (2) tick(4'h0, 0, 0);

    // Single channel, depth 2: one transaction per cycle, then fill and block.
    valid1 = 1'b1; uready1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) chk("d1_tput_valid", uvalid1, 1);
      tick(4'h0, 0, 1);
    end
    uready1 = 1'b0;
    tick(4'h0, 0, 1);
    tick(4'h0, 0, 0);
    valid1 = 1'b0; uready1 = 1'b1;
    repeat (3) tick(4'h0, 0, 0);

    chk("sb0_drained", q0.size(), 0);
    chk("sb1_drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
